// File: rtl/jtpinpon_pkg.sv
// Shared definitions for the PSG write scheduler: FSM encoding and the
// default READY timeout.
package jtpinpon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RECOV  = 2'd3
    } psg_state_e;

    // cen ticks allowed for READY to return before a write is forced complete
    localparam int TO_MAX_DEF = 255;

endpackage

// File: rtl/jtpinpon_psgfifo.sv
// Small register FIFO holding bytes queued for the PSG. Pointers carry an
// extra wrap bit so full and empty are distinguished without a counter.
module jtpinpon_psgfifo #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int DEPTH = 2**AW;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;

    // Storage write port.
    // NOTE: the data array is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    // Pointer registers; they wrap naturally through the extra top bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/jtpinpon_psgctl.sv
// Write scheduler between the main Z80 bus and the SN76489 PSG. The CPU
// writes land in a latch, a trigger access queues the latched byte, and an
// FSM clocked by cen replays queued bytes using the PSG READY handshake.
module jtpinpon_psgctl
    import jtpinpon_pkg::*;
#(
    parameter int AW     = 2,
    parameter int TO_MAX = TO_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          lat_we,
    input  logic [7:0]    lat_din,
    input  logic          trig_we,
    output logic          wait_n,
    output logic [7:0]    psg_din,
    output logic          psg_cs_n,
    output logic          psg_wr_n,
    input  logic          psg_ready,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          to_err
);

    localparam int            CW     = $clog2(TO_MAX + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TO_MAX);

    psg_state_e    state_q, state_d;
    logic [7:0]    lat_q;
    logic          trig_q;
    logic          pend_q, pend_d;
    logic [7:0]    din_q, din_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          trig_rise, push_req, push_ok, pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] cnt_inc;
    logic          timeout;

    jtpinpon_psgfifo #(.AW(AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .din_i   (lat_q),
        .dout_o  (fifo_dout),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A trigger edge, or one held over from a full queue, pushes as soon as
    // there is room; a pop on the same clk makes room at full.
    assign trig_rise = trig_we && !trig_q;
    assign push_req  = trig_rise || pend_q;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign pend_d    = push_req && !push_ok;

    // Timeout counter step, saturating at the limit.
    assign cnt_inc = (cnt_q == TO_LIM) ? cnt_q : cnt_q + CW'(1);
    assign timeout = (cnt_inc == TO_LIM);

    // CPU-side registers: data latch, trigger edge detector, pending push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q  <= '0;
            trig_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            if (lat_we) lat_q <= lat_din;
            trig_q <= trig_we;
            pend_q <= pend_d;
        end
    end

    // Next-state logic for the PSG-side FSM; everything advances only on cen.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pop     = 1'b0;
        if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        din_d   = fifo_dout;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end
                ST_STROBE: begin
                    cnt_d = cnt_inc;
                    if (!psg_ready) begin
                        state_d = ST_RECOV;
                    end else if (timeout) begin
                        pop     = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_RECOV: begin
                    cnt_d = cnt_inc;
                    if (psg_ready) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end else if (timeout) begin
                        pop     = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // PSG-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            din_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from the state so an async reset releases them at once.
    assign psg_cs_n = !((state_q == ST_SETUP) || (state_q == ST_STROBE));
    assign psg_wr_n = !(state_q == ST_STROBE);
    assign psg_din  = din_q;
    assign wait_n   = !pend_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);
    assign to_err   = err_q;

endmodule
